alu_mdu: RTL and testbench

Parametrised, multi-cycle successor to the 32-bit combinational ALU. It executes the base integer ALU operations plus the RV32M multiply/divide group behind a valid/ready handshake. Base ops take one cycle. MUL* and DIV*/REM* use an iterative shift-add / restoring datapath that takes XLEN cycles. It sits in the execute stage of the multi-cycle core and stalls the core while busy.

---
 rtl/alu_mdu_pkg.sv | 67 ++++++
 rtl/alu_mdu_if.sv | 25 ++
 rtl/alu_mdu_iter.sv | 139 +++++++++++++
 rtl/alu_mdu.sv | 103 ++++++++++
 tb/tb_alu_mdu.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU/MDU execute unit: op encodings, FSM states,
// and the single-cycle base-op result function.
package alu_mdu_pkg;

  // Internal width of the base-op function; XLEN may be any power of two up to this.
  localparam int ALU_MAXW = 128;
  localparam int ALU_SHW  = $clog2(ALU_MAXW);

  // Base integer ops (op[4] = 0)
  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SLL    = 5'h01;
  localparam logic [4:0] OP_SLT    = 5'h02;
  localparam logic [4:0] OP_SLTU   = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SRL    = 5'h05;
  localparam logic [4:0] OP_OR     = 5'h06;
  localparam logic [4:0] OP_AND    = 5'h07;
  localparam logic [4:0] OP_SUB    = 5'h08;
  localparam logic [4:0] OP_SRA    = 5'h0D;

  // Multiply / divide ops (op[4] = 1, op[3] = 0)
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Base-op result at ALU_MAXW bits. Callers pass operands both sign- and
  // zero-extended so the low XLEN bits of every result (including SRA and
  // SLT) are correct for the caller's XLEN. Unlisted codes give 0.
  function automatic logic [ALU_MAXW-1:0] base_result(
    input logic [4:0]          op,
    input logic [ALU_MAXW-1:0] a_s,
    input logic [ALU_MAXW-1:0] a_u,
    input logic [ALU_MAXW-1:0] b_s,
    input logic [ALU_MAXW-1:0] b_u,
    input logic [ALU_SHW-1:0]  shamt
  );
    logic [ALU_MAXW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a_u + b_u;
      OP_SUB:  r = a_u - b_u;
      OP_SLL:  r = a_u << shamt;
      OP_SLT:  r = {{(ALU_MAXW-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
      OP_SLTU: r = {{(ALU_MAXW-1){1'b0}}, (a_u < b_u)};
      OP_XOR:  r = a_u ^ b_u;
      OP_SRL:  r = a_u >> shamt;
      OP_OR:   r = a_u | b_u;
      OP_AND:  r = a_u & b_u;
      OP_SRA:  r = $signed(a_s) >>> shamt;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between the core and the ALU/MDU.
interface alu_mdu_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] ra;
  logic [XLEN-1:0] rb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  // Requester side (core)
  modport master (
    output in_valid, op, ra, rb, out_ready,
    input  in_ready, out_valid, result
  );

  // Execution-unit side
  modport slave (
    input  in_valid, op, ra, rb, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath. One shift-add (multiply) or one
// restoring-divide step per cycle for XLEN cycles; the sign fix-up is folded
// into the result presented alongside the done strobe.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int SHW = $clog2(XLEN);

  logic              busy_q, busy_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;

  logic              sign_a, sign_b;
  logic              neg_a_in, neg_b_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;

  // Which operands are treated as signed for the requested function
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (fn)
      3'b001, 3'b100, 3'b110: begin  // MULH, DIV, REM
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      3'b010:  sign_a = 1'b1;        // MULHSU
      default: ;
    endcase
    neg_a_in = sign_a & a[XLEN-1];
    neg_b_in = sign_b & b[XLEN-1];
    mag_a    = neg_a_in ? -a : a;
    mag_b    = neg_b_in ? -b : b;
  end

  // One iteration step. Multiply: {hi,lo} holds partial product / multiplier.
  // Divide: {hi,lo} holds partial remainder / dividend-becoming-quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // Only taken when div_shift >= divisor, so the difference fits in XLEN bits
    div_diff  = div_shift[XLEN-1:0] - opb_q;
    if (fn_q[2]) begin
      acc_step = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select from the final step's value
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[2*XLEN-1:XLEN];
    quo_fix  = (neg_a_q ^ neg_b_q) ? -quo : quo;
    rem_fix  = neg_a_q ? -rem : rem;
    case (fn_q)
      3'b000:                 res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quo_fix;
      default:                res = rem_fix;
    endcase
  end

  assign done = busy_q && (cnt_q == SHW'(XLEN - 1));

  // Next-state: load magnitudes on start, otherwise iterate while busy
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    fn_d    = fn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      fn_d    = fn;
      neg_a_d = neg_a_in;
      neg_b_d = neg_b_in;
      if (fn[2]) begin
        acc_d = {{XLEN{1'b0}}, mag_a};
        opb_d = mag_b;
      end else begin
        acc_d = {{XLEN{1'b0}}, mag_b};
        opb_d = mag_a;
      end
    end else if (busy_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + SHW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  // Datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      fn_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      fn_q    <= fn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with RV32M multiply/divide. Base ops, illegal codes and
// divide special cases complete in one cycle; MUL*/DIV*/REM* iterate XLEN
// cycles in mdu_iter. The result is held in DONE until the consumer takes it.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  alu_mdu_if.slave    bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_mop;
  logic            is_div;
  logic            div_by_zero;
  logic            div_ovf;
  logic            div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] base_res;
  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  // Request decode on the live inputs; only used in the accept cycle
  always_comb begin
    is_mop      = bus.op[4] & ~bus.op[3];
    is_div      = is_mop & bus.op[2];
    div_by_zero = is_div && (bus.rb == '0);
    // Signed DIV/REM have op[0] == 0
    div_ovf     = is_div && !bus.op[0] && (bus.rb == '1) &&
                  (bus.ra == {1'b1, {(XLEN-1){1'b0}}});
    div_special = div_by_zero | div_ovf;
    // op[1] selects remainder over quotient
    if (div_by_zero) special_res = bus.op[1] ? bus.ra : '1;
    else             special_res = bus.op[1] ? '0 : bus.ra;
    base_res = XLEN'(base_result(bus.op,
                                 ALU_MAXW'($signed(bus.ra)), ALU_MAXW'(bus.ra),
                                 ALU_MAXW'($signed(bus.rb)), ALU_MAXW'(bus.rb),
                                 ALU_SHW'(bus.rb[SHW-1:0])));
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
    .clk   (clk),
    .reset (reset),
    .start (mdu_start),
    .fn    (bus.op[2:0]),
    .a     (bus.ra),
    .b     (bus.rb),
    .done  (mdu_done),
    .res   (mdu_res)
  );

  // FSM next-state, result capture and iteration start
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mdu_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_mop && !div_special) begin
            mdu_start = 1'b1;
            state_d   = bus.op[2] ? DIV : MUL;
          end else begin
            state_d  = DONE;
            result_d = !bus.op[4] ? base_res : (div_special ? special_res : '0);
          end
        end
      end
      MUL, DIV: begin
        if (mdu_done) begin
          state_d  = DONE;
          result_d = mdu_res;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected result and latency are pushed when a
// request is driven and popped when the DUT presents its result.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mdu_if #(.XLEN(32)) bus ();
  alu_mdu_if #(.XLEN(16)) bus16 ();

  alu_mdu #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  alu_mdu #(.XLEN(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  typedef struct packed {
    logic [31:0] res;
    int          lat;
    logic [4:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference behaviour computed with 64-bit arithmetic
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'h0, a}; ub = {32'h0, b};
    e.op = op; e.lat = 1; e.res = '0;
    case (op)
      5'h00: e.res = a + b;
      5'h01: e.res = a << b[4:0];
      5'h02: e.res = (ia < ib) ? 32'd1 : 32'd0;
      5'h03: e.res = (a < b) ? 32'd1 : 32'd0;
      5'h04: e.res = a ^ b;
      5'h05: e.res = a >> b[4:0];
      5'h06: e.res = a | b;
      5'h07: e.res = a & b;
      5'h08: e.res = a - b;
      5'h0D: e.res = 32'(ia >>> b[4:0]);
      5'h10: begin p = ua * ub; e.res = p[31:0];  e.lat = 33; end
      5'h11: begin p = sa * sb; e.res = p[63:32]; e.lat = 33; end
      5'h12: begin p = sa * ub; e.res = p[63:32]; e.lat = 33; end
      5'h13: begin p = ua * ub; e.res = p[63:32]; e.lat = 33; end
      5'h14: begin
        if (b == 0) e.res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
        else begin e.res = ia / ib; e.lat = 33; end
      end
      5'h15: begin
        if (b == 0) e.res = 32'hFFFF_FFFF;
        else begin e.res = a / b; e.lat = 33; end
      end
      5'h16: begin
        if (b == 0) e.res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'h0;
        else begin e.res = ia % ib; e.lat = 33; end
      end
      5'h17: begin
        if (b == 0) e.res = a;
        else begin e.res = a % b; e.lat = 33; end
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.op, bus.ra, bus.rb));
  end

  // Present one request for exactly one clock edge (called only from IDLE)
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.ra = a; bus.rb = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles from accept
  task automatic wait_out(output int lat, output bit timeout);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    timeout = !bus.out_valid;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.ra = '0; bus.rb = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.op = '0; bus16.ra = '0; bus16.rb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", bus.result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Run a list of requests through the scoreboard, one at a time
  task automatic test_base();
    logic [4:0]  ops[9] = '{5'h00, 5'h0D, 5'h08, 5'h02, 5'h03, 5'h01, 5'h05, 5'h09, 5'h18};
    logic [31:0] as[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h1, 32'h8000_0000, 32'h1234, 32'h55};
    logic [31:0] bs[9]  = '{32'h1, 32'h24, 32'h7, 32'h1, 32'h1, 32'h3F, 32'h21, 32'h1, 32'h2};
    int lat; bit to; exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], as[i], bs[i]);
      wait_out(lat, to);
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL base_queue_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        $display("txn base op=%h a=%h b=%h res=%h lat=%0d", ops[i], as[i], bs[i], bus.result, lat);
        checks++; if (to || bus.result !== e.res) begin errors++; $display("FAIL base_result op=%h got=%h want=%h", ops[i], bus.result, e.res); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL base_latency op=%h got=%0d want=%0d", ops[i], lat, e.lat); end
      end
      consume();
    end
    // Directed values straight from the expected behaviour
    drive(OP_SRA, 32'h8000_0000, 32'h24); wait_out(lat, to);
    checks++; if (bus.result !== 32'hF800_0000) begin errors++; $display("FAIL sra_const got=%h want=f8000000", bus.result); end
    void'(exp_q.pop_front()); consume();
  endtask

  task automatic test_mdu();
    logic [4:0]  ops[12] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_DIV, OP_REM,
                             OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REMU};
    logic [31:0] as[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd100};
    logic [31:0] bs[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7};
    logic [31:0] want[12] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFD, 32'd2};
    int lat; bit to; exp_t e;
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], as[i], bs[i]);
      wait_out(lat, to);
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL mdu_queue_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        $display("txn mdu op=%h a=%h b=%h res=%h lat=%0d", ops[i], as[i], bs[i], bus.result, lat);
        checks++; if (to || bus.result !== e.res) begin errors++; $display("FAIL mdu_result op=%h got=%h want=%h", ops[i], bus.result, e.res); end
        checks++; if (bus.result !== want[i]) begin errors++; $display("FAIL mdu_const op=%h got=%h want=%h", ops[i], bus.result, want[i]); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL mdu_latency op=%h got=%0d want=%0d", ops[i], lat, e.lat); end
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_div();
    int lat; bit to; exp_t e;
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL middiv_busy got valid=%b ready=%b want 0 0", bus.out_valid, bus.in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL middiv_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL middiv_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL middiv_result got=%h want=00000000", bus.result); end
    drive(OP_ADD, 32'd2, 32'd3);
    wait_out(lat, to);
    e = exp_q.pop_front();
    $display("txn after_reset op=00 res=%h lat=%0d", bus.result, lat);
    checks++; if (to || bus.result !== 32'd5 || bus.result !== e.res) begin errors++; $display("FAIL middiv_add got=%h want=00000005", bus.result); end
    checks++; if (lat != 1) begin errors++; $display("FAIL middiv_add_latency got=%0d want=1", lat); end
    consume();
    // The aborted divide must not surface later
    repeat (40) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL middiv_stale got out_valid=%b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int lat; bit to; exp_t e; logic [31:0] held;
    drive(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out(lat, to);
    e = exp_q.pop_front();
    held = bus.result;
    $display("txn bp op=13 res=%h lat=%0d", bus.result, lat);
    checks++; if (to || held !== e.res) begin errors++; $display("FAIL bp_result got=%h want=%h", held, e.res); end
    bus.op = OP_ADD; bus.ra = 32'd1; bus.rb = 32'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== e.res || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got res=%h ready=%b valid=%b want res=%h ready=0 valid=1", i, bus.result, bus.in_ready, bus.out_valid, e.res);
      end
    end
    // Release with in_valid still high: the DONE cycle must not accept it
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL bp_extra got valid=%b queued=%0d want 0 0", bus.out_valid, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; exp_t e;
    logic [4:0] op; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom; b = $urandom;
      if (i % 6 == 1) b = 32'h0;
      if (i % 6 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 4 == 2) b = b >> $urandom_range(0, 31);
      drive(op, a, b);
      wait_out(lat, to);
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL b2b_queue_empty idx=%0d", i); end
      else begin
        e = exp_q.pop_front();
        $display("txn b2b op=%h a=%h b=%h res=%h lat=%0d", op, a, b, bus.result, lat);
        checks++; if (to || bus.result !== e.res) begin errors++; $display("FAIL b2b_result op=%h got=%h want=%h", op, bus.result, e.res); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_latency op=%h got=%0d want=%0d", op, lat, e.lat); end
      end
      consume();
    end
  endtask

  task automatic test_xlen16();
    int lat;
    // MULHU 0xFFFF * 0xFFFF, expect 0xFFFE after XLEN+1 = 17 cycles
    bus16.op = OP_MULHU; bus16.ra = 16'hFFFF; bus16.rb = 16'hFFFF; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("txn x16 op=13 res=%h lat=%0d", bus16.result, lat);
    checks++; if (bus16.result !== 16'hFFFE) begin errors++; $display("FAIL x16_mulhu got=%h want=fffe", bus16.result); end
    checks++; if (lat != 17) begin errors++; $display("FAIL x16_mulhu_latency got=%0d want=17", lat); end
    bus16.out_ready = 1'b1; @(posedge clk); #1; bus16.out_ready = 1'b0;
    // SLL uses only rb[3:0]: 0x13 shifts by 3
    bus16.op = OP_SLL; bus16.ra = 16'h0001; bus16.rb = 16'h0013; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("txn x16 op=01 res=%h lat=%0d", bus16.result, lat);
    checks++; if (bus16.result !== 16'h0008) begin errors++; $display("FAIL x16_sll got=%h want=0008", bus16.result); end
    checks++; if (lat != 1) begin errors++; $display("FAIL x16_sll_latency got=%0d want=1", lat); end
    bus16.out_ready = 1'b1; @(posedge clk); #1; bus16.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_base();
    test_mdu();
    test_reset_mid_div();
    test_backpressure();
    test_back_to_back();
    test_xlen16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
